// File: rtl/alu_dispatch_if.sv
// rtl/alu_dispatch_if.sv - request/response handshake bundle for the ALU dispatcher
// Signals:
//   req_valid/req_ready/req_op/req_a/req_b : request channel (producer -> dispatcher)
//   rsp_valid/rsp_ready/rsp_data/rsp_ovf/rsp_zero/rsp_err : response channel (dispatcher -> consumer)
// Modports: master = requester/consumer side, slave = dispatcher side.
interface alu_dispatch_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_ovf;
    logic       rsp_zero;
    logic       rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - issue-side sequencer for the 8-bit Power ALU
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : request/response handshake channels
//   a_out, b_out        : operands driven to compare/andornot/addsub
//   fn_out              : sub-function select for andornot/addsub
//   mux_ctrl            : result mux select (11 = idle, mux yields 0)
//   res_in, ovf_in      : result mux output and addsub overflow, sampled at capture
//   busy                : high whenever the dispatcher is not idle
module alu_dispatch #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_dispatch_if.slave bus,
    output logic [7:0]    a_out,
    output logic [7:0]    b_out,
    output logic [1:0]    fn_out,
    output logic [1:0]    mux_ctrl,
    input  logic [7:0]    res_in,
    input  logic          ovf_in,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [1:0] MUX_CMP  = 2'b00;
    localparam logic [1:0] MUX_AON  = 2'b01;
    localparam logic [1:0] MUX_ADD  = 2'b10;
    localparam logic [1:0] MUX_IDLE = 2'b11;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;

    logic       dec_legal;
    logic [1:0] dec_fn;
    logic [1:0] dec_mux;
    logic       accept;
    logic       capture;

    // Opcode decode into mux select and sub-function.
    always_comb begin
        dec_legal = 1'b1;
        dec_fn    = 2'b00;
        dec_mux   = MUX_IDLE;
        case (bus.req_op)
            3'b000: dec_mux = MUX_CMP;
            3'b001: begin dec_mux = MUX_AON; dec_fn = 2'b00; end
            3'b010: begin dec_mux = MUX_AON; dec_fn = 2'b01; end
            3'b011: begin dec_mux = MUX_AON; dec_fn = 2'b10; end
            3'b100: begin dec_mux = MUX_ADD; dec_fn = 2'b00; end
            3'b101: begin dec_mux = MUX_ADD; dec_fn = 2'b01; end
            default: dec_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = dec_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/strobe logic.
    always_comb begin
        bus.req_ready = (state == IDLE);
        busy          = (state != IDLE);
        accept        = (state == IDLE) && bus.req_valid;
        capture       = (state == ISSUE) && (cnt == 4'd0);
    end

    // Datapath registers: operands and selects latch on accept only, response
    // fields latch on capture (or immediately for an illegal opcode).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out        <= 8'h00;
            b_out        <= 8'h00;
            fn_out       <= 2'b00;
            mux_ctrl     <= MUX_IDLE;
            cnt          <= 4'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 8'h00;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                if (dec_legal) begin
                    a_out    <= bus.req_a;
                    b_out    <= bus.req_b;
                    fn_out   <= dec_fn;
                    mux_ctrl <= dec_mux;
                    cnt      <= SETTLE_LOAD;
                end else begin
                    bus.rsp_data  <= 8'h00;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_ovf   <= 1'b0;
                    bus.rsp_zero  <= 1'b1;
                    bus.rsp_valid <= 1'b1;
                end
            end

            if (state == ISSUE) begin
                if (capture) begin
                    bus.rsp_data  <= res_in;
                    // Overflow is only meaningful for the addsub path.
                    bus.rsp_ovf   <= (mux_ctrl == MUX_ADD) ? ovf_in : 1'b0;
                    bus.rsp_zero  <= (res_in == 8'h00);
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    mux_ctrl      <= MUX_IDLE;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end

            if ((state == RESP) && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - directed self-checking bench for alu_dispatch
module tb_alu_dispatch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_dispatch_if bus1();
    alu_dispatch_if bus2();

    logic [7:0] a1, b1, res1;
    logic [1:0] fn1, mux1;
    logic       ovf1, busy1;
    logic [7:0] a2, b2, res2;
    logic [1:0] fn2, mux2;
    logic       ovf2, busy2;

    alu_dispatch #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .a_out(a1), .b_out(b1), .fn_out(fn1), .mux_ctrl(mux1),
        .res_in(res1), .ovf_in(ovf1), .busy(busy1)
    );

    alu_dispatch #(.SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .a_out(a2), .b_out(b2), .fn_out(fn2), .mux_ctrl(mux2),
        .res_in(res2), .ovf_in(ovf2), .busy(busy2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       ovf;
        logic [1:0] mux;
        logic [1:0] fn;
        logic [7:0] data;
        logic       vovf;
        logic       zero;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        //            op      a      b      res    ovf   mux    fn     data   vovf  zero  err
        vecs[0] = '{3'b100, 8'h7F, 8'h01, 8'h80, 1'b1, 2'b10, 2'b00, 8'h80, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{3'b001, 8'hF0, 8'h0F, 8'h00, 1'b1, 2'b01, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{3'b000, 8'h03, 8'h09, 8'h01, 1'b1, 2'b00, 2'b00, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{3'b010, 8'h0C, 8'h30, 8'h3C, 1'b0, 2'b01, 2'b01, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{3'b011, 8'hF0, 8'h00, 8'h0F, 1'b1, 2'b01, 2'b10, 8'h0F, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3'b101, 8'h05, 8'h05, 8'h00, 1'b0, 2'b10, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{3'b111, 8'h12, 8'h34, 8'h55, 1'b1, 2'b11, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{3'b110, 8'h56, 8'h78, 8'hAA, 1'b1, 2'b11, 2'b00, 8'h00, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_op = 3'b000; bus1.req_a = 8'h00; bus1.req_b = 8'h00;
        bus1.rsp_ready = 1'b0;
        bus2.req_valid = 1'b0; bus2.req_op = 3'b000; bus2.req_a = 8'h00; bus2.req_b = 8'h00;
        bus2.rsp_ready = 1'b0;
        res1 = 8'h00; ovf1 = 1'b0; res2 = 8'h00; ovf2 = 1'b0;

        // Reset asserted between edges must take effect without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mux1", mux1, 2'b11);
        chk("rst_mux2", mux2, 2'b11);
        chk("rst_a", a1, 8'h00);
        chk("rst_b", b1, 8'h00);
        chk("rst_fn", fn1, 2'b00);
        chk("rst_data", bus1.rsp_data, 8'h00);
        chk("rst_flags", {bus1.rsp_valid, bus1.rsp_ovf, bus1.rsp_zero, bus1.rsp_err, busy1}, 5'b0);
        chk("rst_flags2", {bus2.rsp_valid, bus2.rsp_ovf, bus2.rsp_zero, bus2.rsp_err, busy2}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready1", bus1.req_ready, 1'b1);
        chk("rst_req_ready2", bus2.req_ready, 1'b1);

        // Table-driven single transactions on the SETTLE_CYCLES=1 instance.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus1.req_valid = 1'b1;
            bus1.req_op = vecs[i].op; bus1.req_a = vecs[i].a; bus1.req_b = vecs[i].b;
            res1 = vecs[i].res; ovf1 = vecs[i].ovf;
            @(negedge clk);
            bus1.req_valid = 1'b0;
            bus1.req_op = 3'b000; bus1.req_a = 8'hEE; bus1.req_b = 8'hDD;
            if (!vecs[i].err) begin
                chk($sformatf("v%0d_mux", i), mux1, vecs[i].mux);
                chk($sformatf("v%0d_fn", i), fn1, vecs[i].fn);
                chk($sformatf("v%0d_ops", i), {a1, b1}, {vecs[i].a, vecs[i].b});
                chk($sformatf("v%0d_early", i), bus1.rsp_valid, 1'b0);
                @(negedge clk);
            end
            chk($sformatf("v%0d_valid", i), bus1.rsp_valid, 1'b1);
            chk($sformatf("v%0d_data", i), bus1.rsp_data, vecs[i].data);
            chk($sformatf("v%0d_flags", i), {bus1.rsp_ovf, bus1.rsp_zero, bus1.rsp_err},
                {vecs[i].vovf, vecs[i].zero, vecs[i].err});
            chk($sformatf("v%0d_mux_idle", i), mux1, 2'b11);
            bus1.rsp_ready = 1'b1;
            @(negedge clk);
            bus1.rsp_ready = 1'b0;
            chk($sformatf("v%0d_done", i), {bus1.rsp_valid, bus1.req_ready, busy1}, 3'b010);
        end

        // Backpressure with a second request waiting throughout.
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_op = 3'b100; bus1.req_a = 8'h01; bus1.req_b = 8'h02;
        res1 = 8'h03; ovf1 = 1'b0;
        @(negedge clk);
        bus1.req_op = 3'b001; bus1.req_a = 8'hAA; bus1.req_b = 8'h55;
        @(negedge clk);
        res1 = 8'h99; ovf1 = 1'b1;
        chk("bp_first", {bus1.rsp_valid, bus1.rsp_data}, {1'b1, 8'h03});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", c), {bus1.rsp_valid, bus1.rsp_data, bus1.rsp_ovf, bus1.rsp_zero},
                {1'b1, 8'h03, 1'b0, 1'b0});
            chk($sformatf("bp_busy%0d", c), {bus1.req_ready, busy1, a1}, {1'b0, 1'b1, 8'h01});
        end
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;
        chk("bp_release", {bus1.rsp_valid, bus1.req_ready, busy1}, 3'b010);
        res1 = 8'h00; ovf1 = 1'b1;
        @(negedge clk);
        bus1.req_valid = 1'b0;
        chk("bp_second_acc", {busy1, mux1, a1, b1}, {1'b1, 2'b01, 8'hAA, 8'h55});
        @(negedge clk);
        chk("bp_second_rsp", {bus1.rsp_valid, bus1.rsp_data, bus1.rsp_ovf, bus1.rsp_zero},
            {1'b1, 8'h00, 1'b0, 1'b1});
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        bus1.rsp_ready = 1'b0;

        // SETTLE_CYCLES=3 subtract; result appears only in the last ISSUE cycle.
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_op = 3'b101; bus2.req_a = 8'h05; bus2.req_b = 8'h07;
        res2 = 8'h11; ovf2 = 1'b1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        chk("s3_acc", {fn2, mux2, a2, b2}, {2'b01, 2'b10, 8'h05, 8'h07});
        @(negedge clk);
        chk("s3_k1", bus2.rsp_valid, 1'b0);
        @(negedge clk);
        chk("s3_k2", bus2.rsp_valid, 1'b0);
        res2 = 8'hFE; ovf2 = 1'b0;
        @(negedge clk);
        chk("s3_k3", {bus2.rsp_valid, bus2.rsp_data, bus2.rsp_ovf, bus2.rsp_zero, bus2.rsp_err},
            {1'b1, 8'hFE, 1'b0, 1'b0, 1'b0});
        chk("s3_mux_idle", mux2, 2'b11);
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
        chk("s3_done", {bus2.rsp_valid, bus2.req_ready}, 2'b01);

        // Repeat, aborted by reset during ISSUE: the response must never appear.
        bus2.req_valid = 1'b1;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_issue", {busy2, bus2.rsp_valid}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("abort_rst", {busy2, bus2.rsp_valid, mux2, a2}, {1'b0, 1'b0, 2'b11, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("abort_quiet%0d", c), {bus2.rsp_valid, busy2, bus2.req_ready}, 3'b001);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Issue-side sequencer for the 8-bit Power ALU. It accepts an opcode and two operands over a valid/ready request interface.
- It drives operands and function select into the compare, andornot and addsub modules, and drives the result mux select.
- After a fixed settle time it captures the mux output and overflow, then returns the captured result over a valid/ready response interface.
- It is the producing end of the ctrl/operand path whose results the result mux collects.

Parameters:
- SETTLE_CYCLES, 1, number of cycles mux_ctrl/operands are held before the result is captured; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  dispatcher can accept; equals (state==IDLE).
- req_op  in  3  000 cmp, 001 and, 010 or, 011 not, 100 add, 101 sub, 110/111 illegal.
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- a_out  out  8  operand A to ALU modules.
- b_out  out  8  operand B to ALU modules.
- fn_out  out  2  sub-function: and=00, or=01, not=10 for andornot; add=00, sub=01 for addsub; 00 otherwise.
- mux_ctrl  out  2  result mux select: 00 compare, 01 andornot, 10 addsub, 11 idle (mux yields 0).
- res_in  in  8  result mux output.
- ovf_in  in  1  addsub overflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8  captured result.
- rsp_ovf  out  1  captured overflow; 0 for non-arithmetic ops.
- rsp_zero  out  1  rsp_data==8'h00.
- rsp_err  out  1  illegal opcode.
- busy  out  1  state!=IDLE.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE, mux_ctrl=2'b11.
  - a_out, b_out, fn_out, rsp_data = 0.
  - rsp_valid, rsp_ovf, rsp_zero, rsp_err, busy = 0.
  - Settle counter = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1.
  - On edge with req_valid=1, legal op: register a_out/b_out/fn_out/mux_ctrl from the decode, load counter with SETTLE_CYCLES-1, go ISSUE.
  - Illegal op: rsp_data=0, rsp_err=1, rsp_ovf=0, rsp_zero=1, rsp_valid=1, mux_ctrl stays 11, go RESP.
- ISSUE:
  - mux_ctrl, fn_out and operands stay stable.
  - Counter decrements each edge.
  - On the edge where counter==0: rsp_data<=res_in, rsp_ovf<=ovf_in only if mux_ctrl==10 (else 0), rsp_zero<=(res_in==0), rsp_err<=0, rsp_valid<=1, mux_ctrl<=11, go RESP.
- Latency: for a request accepted on edge k, rsp_valid is first high after edge k+SETTLE_CYCLES.
- RESP:
  - rsp_* stay stable while rsp_valid=1 and rsp_ready=0; backpressure holds indefinitely.
  - On edge with rsp_ready=1: rsp_valid<=0, go IDLE. rsp_data and the flags hold their values until the next capture.
  - req_ready=0, so a new request is accepted no earlier than the edge after the response handshake. Minimum request spacing is SETTLE_CYCLES+2 cycles.
- a_out/b_out hold their last issued values in IDLE/RESP; they change only on accept.
- Inputs req_* are sampled only on the accept edge; later changes to them are ignored.
- res_in/ovf_in are ignored outside the capture edge.
- Reset mid-ISSUE or mid-RESP aborts immediately to reset values; the pending response is dropped.
- A compare result is passed as given by the compare module (8-bit); no reinterpretation.

Test Plan:
1. Reset: rst_n low mid-cycle -> all outputs 0 and mux_ctrl=11 without a clock edge; req_ready=1 after release.
2. Add, SETTLE_CYCLES=1: req_op=100, a=8'h7F, b=8'h01 accepted at edge k.
   - Drive res_in=8'h80, ovf_in=1.
   - Require: mux_ctrl=10, fn_out=00 after edge k; rsp_valid=1, rsp_data=80, rsp_ovf=1, rsp_zero=0 after edge k+1.
3. And with overflow masking: req_op=001, a=F0, b=0F, res_in=00, ovf_in=1.
   - Require: mux_ctrl=01, fn_out=00; rsp_data=00, rsp_zero=1, rsp_ovf=0.
4. Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, req_ready=0, busy=1.
   - rsp_ready=1 one cycle -> IDLE next edge; a second req_valid asserted throughout is accepted exactly one edge later.
5. Illegal op: req_op=111 -> rsp_valid one edge after accept, rsp_err=1, rsp_data=0, mux_ctrl stays 11.
6. SETTLE_CYCLES=3, sub: a=05, b=07, res_in changes to FE only in the last ISSUE cycle.
   - Require: fn_out=01, rsp_data=FE after edge k+3. Assert rst_n low during ISSUE in a repeat run -> no rsp_valid.
